// File: rtl/multicycle_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS-style controller.
// Optional feature macro: MULTICYCLE_CTRL_BNE_EN (adds the bne opcode).
package multicycle_ctrl_pkg;

    localparam int unsigned STATE_W    = 4;
    localparam int unsigned OP_W       = 6;
    localparam int unsigned ALU_CODE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEXEC = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
`ifdef MULTICYCLE_CTRL_BNE_EN
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
`endif

    localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
    localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
    localparam logic [OP_W-1:0] FN_AND = 6'b100100;
    localparam logic [OP_W-1:0] FN_OR  = 6'b100101;
    localparam logic [OP_W-1:0] FN_SLT = 6'b101010;

    localparam logic [ALU_CODE_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_CODE_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_CODE_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_CODE_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_CODE_W-1:0] ALU_SLT = 3'b111;

    // Per-state datapath control word before mem_ready gating is folded in.
    typedef struct packed {
        logic       MemToReg;
        logic       RegDst;
        logic       IorD;
        logic       ALUSrcA;
        logic       IRWrite;
        logic       MemWrite;
        logic       PCWrite;
        logic       Branch;
        logic       RegWrite;
        logic [1:0] PCSrc;
        logic [1:0] ALUSrcB;
        alu_op_t    alu_op;
    } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and status in, controls out.
interface multicycle_ctrl_if #(
    parameter int unsigned ALU_CTRL_W = 3
);
    logic [5:0]            Opcode;
    logic [5:0]            Funct;
    logic                  zero;
    logic                  mem_ready;
    logic                  MemToReg;
    logic                  RegDst;
    logic                  IorD;
    logic                  ALUSrcA;
    logic                  IRWrite;
    logic                  MemWrite;
    logic                  PCWrite;
    logic                  Branch;
    logic                  RegWrite;
    logic [1:0]            PCSrc;
    logic [1:0]            ALUSrcB;
    logic [ALU_CTRL_W-1:0] ALUControl;
    logic                  PCEn;
    logic                  illegal;
    logic                  mem_timeout;
    logic [3:0]            state_o;

    modport master (
        input  Opcode, Funct, zero, mem_ready,
        output MemToReg, RegDst, IorD, ALUSrcA, IRWrite, MemWrite, PCWrite,
               Branch, RegWrite, PCSrc, ALUSrcB, ALUControl, PCEn, illegal,
               mem_timeout, state_o
    );

    modport slave (
        output Opcode, Funct, zero, mem_ready,
        input  MemToReg, RegDst, IorD, ALUSrcA, IRWrite, MemWrite, PCWrite,
               Branch, RegWrite, PCSrc, ALUSrcB, ALUControl, PCEn, illegal,
               mem_timeout, state_o
    );
endinterface

// File: rtl/multicycle_alu_dec.sv
// ALU decoder: ALU-op class plus Funct field -> 3-bit ALUControl code.
module multicycle_alu_dec
    import multicycle_ctrl_pkg::*;
(
    input  alu_op_t                alu_op,
    input  logic [OP_W-1:0]        funct,
    output logic [ALU_CODE_W-1:0]  alu_ctrl_c,
    output logic                   funct_valid_c
);

    logic [ALU_CODE_W-1:0] fn_code;

    // Funct decode is independent of alu_op so DECODE can flag bad R-types.
    always_comb begin
        fn_code       = ALU_ADD;
        funct_valid_c = 1'b1;
        case (funct)
            FN_ADD:  fn_code = ALU_ADD;
            FN_SUB:  fn_code = ALU_SUB;
            FN_AND:  fn_code = ALU_AND;
            FN_OR:   fn_code = ALU_OR;
            FN_SLT:  fn_code = ALU_SLT;
            default: funct_valid_c = 1'b0;
        endcase
    end

    // Select the final ALU operation.
    always_comb begin
        alu_ctrl_c = ALU_ADD;
        case (alu_op)
            ALUOP_SUB:   alu_ctrl_c = ALU_SUB;
            ALUOP_FUNCT: alu_ctrl_c = fn_code;
            default:     alu_ctrl_c = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset main controller with memory-wait watchdog.
// Optional macro MULTICYCLE_CTRL_BNE_EN: adds bne (branch when zero=0).
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CNT_W = 4,
    parameter int unsigned ALU_CTRL_W = 3
) (
    input  logic                clk,
    input  logic                reset,
    multicycle_ctrl_if.master   bus
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_MAX = '1;

    state_t                 state, state_next, dec_state;
    logic [WAIT_CNT_W-1:0]  wait_cnt, wait_cnt_next;
    ctrl_t                  ctl;
    logic                   is_mem, expire, illegal_c, timeout_c;
    logic [ALU_CODE_W-1:0]  alu_ctrl_c;
    logic                   funct_valid_c;
    logic                   branch_take_c;

    multicycle_alu_dec u_alu_dec (
        .alu_op        (ctl.alu_op),
        .funct         (bus.Funct),
        .alu_ctrl_c    (alu_ctrl_c),
        .funct_valid_c (funct_valid_c)
    );

    // State and watchdog registers; reset wins over any pending transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Next-state, Moore controls (FETCH decode while in reset), watchdog.
    always_comb begin
        dec_state  = reset ? S_FETCH : state;
        is_mem     = dec_state inside {S_FETCH, S_MEMREAD, S_MEMWRITE};
        expire     = is_mem && (wait_cnt == WAIT_MAX) && !reset;
        state_next = state;
        ctl        = '0;
        ctl.alu_op = ALUOP_ADD;
        illegal_c  = 1'b0;
        timeout_c  = 1'b0;

        case (dec_state)
            S_FETCH: begin
                ctl.ALUSrcB = 2'b01;
                if (expire) begin
                    timeout_c  = 1'b1;
                    state_next = S_FETCH;
                end else if (bus.mem_ready) begin
                    ctl.IRWrite = 1'b1;
                    ctl.PCWrite = 1'b1;
                    state_next  = S_DECODE;
                end
            end
            S_DECODE: begin
                ctl.ALUSrcB = 2'b11;
                case (bus.Opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE: begin
                        if (funct_valid_c) begin
                            state_next = S_EXECUTE;
                        end else begin
                            illegal_c  = 1'b1;
                            state_next = S_FETCH;
                        end
                    end
                    OP_BEQ:  state_next = S_BRANCH;
`ifdef MULTICYCLE_CTRL_BNE_EN
                    OP_BNE:  state_next = S_BRANCH;
`endif
                    OP_ADDI: state_next = S_ADDIEXEC;
                    OP_J:    state_next = S_JUMP;
                    default: begin
                        illegal_c  = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ctl.ALUSrcA = 1'b1;
                ctl.ALUSrcB = 2'b10;
                state_next  = (bus.Opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                ctl.IorD = 1'b1;
                if (expire) begin
                    timeout_c  = 1'b1;
                    state_next = S_FETCH;
                end else if (bus.mem_ready) begin
                    state_next = S_MEMWB;
                end
            end
            S_MEMWB: begin
                ctl.MemToReg = 1'b1;
                ctl.RegWrite = 1'b1;
                state_next   = S_FETCH;
            end
            S_MEMWRITE: begin
                ctl.IorD = 1'b1;
                if (expire) begin
                    timeout_c  = 1'b1;
                    state_next = S_FETCH;
                end else if (bus.mem_ready) begin
                    ctl.MemWrite = 1'b1;
                    state_next   = S_FETCH;
                end
            end
            S_EXECUTE: begin
                ctl.ALUSrcA = 1'b1;
                ctl.alu_op  = ALUOP_FUNCT;
                state_next  = S_ALUWB;
            end
            S_ALUWB: begin
                ctl.RegDst   = 1'b1;
                ctl.RegWrite = 1'b1;
                state_next   = S_FETCH;
            end
            S_BRANCH: begin
                ctl.ALUSrcA = 1'b1;
                ctl.alu_op  = ALUOP_SUB;
                ctl.PCSrc   = 2'b01;
                ctl.Branch  = 1'b1;
                state_next  = S_FETCH;
            end
            S_ADDIEXEC: begin
                ctl.ALUSrcA = 1'b1;
                ctl.ALUSrcB = 2'b10;
                state_next  = S_ADDIWB;
            end
            S_ADDIWB: begin
                ctl.RegWrite = 1'b1;
                state_next   = S_FETCH;
            end
            S_JUMP: begin
                ctl.PCSrc   = 2'b10;
                ctl.PCWrite = 1'b1;
                state_next  = S_FETCH;
            end
            default: state_next = S_FETCH;
        endcase

        // A timeout retry counts as re-entering FETCH, so it clears too.
        if ((state_next != state) || expire || bus.mem_ready || !is_mem) begin
            wait_cnt_next = '0;
        end else begin
            wait_cnt_next = wait_cnt + WAIT_CNT_W'(1);
        end
    end

    // Branch condition: bne inverts the zero test when enabled.
`ifdef MULTICYCLE_CTRL_BNE_EN
    assign branch_take_c = (bus.Opcode == OP_BNE) ? ~bus.zero : bus.zero;
`else
    assign branch_take_c = bus.zero;
`endif

    assign bus.MemToReg    = ctl.MemToReg;
    assign bus.RegDst      = ctl.RegDst;
    assign bus.IorD        = ctl.IorD;
    assign bus.ALUSrcA     = ctl.ALUSrcA;
    assign bus.IRWrite     = ctl.IRWrite;
    assign bus.MemWrite    = ctl.MemWrite;
    assign bus.PCWrite     = ctl.PCWrite;
    assign bus.Branch      = ctl.Branch;
    assign bus.RegWrite    = ctl.RegWrite;
    assign bus.PCSrc       = ctl.PCSrc;
    assign bus.ALUSrcB     = ctl.ALUSrcB;
    assign bus.ALUControl  = ALU_CTRL_W'(alu_ctrl_c);
    assign bus.PCEn        = ctl.PCWrite | (ctl.Branch & branch_take_c);
    assign bus.illegal     = illegal_c;
    assign bus.mem_timeout = timeout_c;
    assign bus.state_o     = state;

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter WAIT_CNT_W, default 4: memory-wait watchdog counter width; timeout limit = 2**WAIT_CNT_W-1 cycles.
REQ-002 Parameter ALU_CTRL_W, default 3: ALUControl width; codes occupy the low 3 bits, upper bits are 0.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 Opcode  in  6  instruction bits [31:26]; Funct  in  6  instruction bits [5:0].
REQ-006 zero  in  1  ALU zero flag; mem_ready  in  1  memory access completes this cycle.
REQ-007 MemToReg, RegDst, IorD, ALUSrcA, IRWrite, MemWrite, PCWrite, Branch, RegWrite  out  1 each  datapath controls.
REQ-008 PCSrc  out  2;  ALUSrcB  out  2;  ALUControl  out  ALU_CTRL_W.
REQ-009 PCEn  out  1  PC register enable; illegal  out  1  one-cycle pulse, unsupported instruction; mem_timeout  out  1  one-cycle pulse, watchdog expiry.
REQ-010 state_o  out  4  current state encoding, for debug.

Function
REQ-011 States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP; Moore outputs, except the mem_ready gating in REQ-014 and PCEn.
REQ-012 Transitions: FETCH->DECODE on mem_ready; DECODE-> MEMADR (lw 100011, sw 101011), EXECUTE (R-type 000000), BRANCH (beq 000100), ADDIEXEC (addi 001000), JUMP (j 000010); MEMADR->MEMREAD (lw) / MEMWRITE (sw); MEMREAD->MEMWB on mem_ready; EXECUTE->ALUWB; ADDIEXEC->ADDIWB; MEMWB, MEMWRITE (on mem_ready), ALUWB, ADDIWB, BRANCH, JUMP -> FETCH.
REQ-013 Outputs per state (unlisted = 0, ALU op add): FETCH ALUSrcB=01, IRWrite, PCWrite; DECODE ALUSrcB=11; MEMADR/ADDIEXEC ALUSrcA=1, ALUSrcB=10; MEMREAD IorD; MEMWB MemToReg, RegWrite; MEMWRITE IorD, MemWrite; EXECUTE ALUSrcA=1, ALU op funct; ALUWB RegDst, RegWrite; ADDIWB RegWrite; BRANCH ALUSrcA=1, ALU op sub, PCSrc=01, Branch; JUMP PCSrc=10, PCWrite.
REQ-014 IRWrite and PCWrite in FETCH, and MemWrite in MEMWRITE, assert only in cycles where mem_ready=1 (single write per access).
REQ-015 ALUControl: add 010, sub 110; funct op: 100000->010, 100010->110, 100100->000, 100101->001, 101010->111.
REQ-016 PCEn = PCWrite | (Branch & zero), combinational, same cycle.
REQ-017 Unsupported opcode, or R-type with unsupported Funct, in DECODE: illegal pulses that cycle, next state FETCH, no register/memory write.
REQ-018 Watchdog: counter clears on every state entry and when mem_ready=1; increments each FETCH/MEMREAD/MEMWRITE cycle with mem_ready=0; on reaching 2**WAIT_CNT_W-1 -> mem_timeout pulse, next state FETCH (retry), no write asserted that cycle.
REQ-019 mem_ready in non-memory states is ignored.

Reset
REQ-020 reset=1 at a clock edge: state FETCH, watchdog 0, illegal=0, mem_timeout=0; overrides any pending transition, including mid-access.
REQ-021 During and immediately after reset, outputs equal FETCH decode with mem_ready gating; MemWrite, RegWrite = 0.

Configuration
REQ-022 Macro MULTICYCLE_CTRL_BNE_EN: defined -> opcode 000101 (bne) DECODE->BRANCH with PCEn term Branch & ~zero for bne; undefined -> 000101 is illegal per REQ-017.

Structure
REQ-023 Package multicycle_ctrl_pkg: state encoding, opcode and funct constants, ALUControl codes, ALU-op encoding (00 add, 01 sub, 10 funct).
REQ-024 Sub-module multicycle_alu_dec: combinational ALU-op + Funct -> ALUControl and funct-valid flag.

Verification
REQ-025 Reset then lw (100011) with mem_ready=1 always -> FETCH,DECODE,MEMADR,MEMREAD,MEMWB,FETCH; RegWrite=1, MemToReg=1 only in MEMWB.
REQ-026 R-type add (Funct 100000), mem_ready=1 -> EXECUTE ALUControl=010, ALUWB RegDst=1 RegWrite=1; Funct 101010 -> ALUControl=111.
REQ-027 beq with zero=1 -> PCEn=1 in BRANCH; zero=0 -> PCEn=0; with macro, bne zero=0 -> PCEn=1; without macro, bne -> illegal pulse, FETCH.
REQ-028 FETCH with mem_ready=0 for 3 cycles then 1 -> IRWrite/PCWrite high exactly one cycle (4th); no timeout.
REQ-029 WAIT_CNT_W=4, sw with mem_ready held 0 in MEMWRITE -> mem_timeout pulse after 15 wait cycles, MemWrite never 1, next state FETCH.
REQ-030 reset asserted in MEMREAD -> next cycle state_o=FETCH, RegWrite=0.
